// File: rtl/mac_result_buffer.sv
// mac_result_buffer
//   Accumulates N_TERMS unsigned products a_in*b_in into one dot-product
//   result. Each completed result is pushed into a small first-word-fall-through
//   FIFO, which drains through a valid/ready port.
//
// Handshake: a word moves on the output port in every cycle where
//   dout_valid=1 and dout_ready=1 at the same rising edge. dout_valid never
//   depends on dout_ready. dout holds the FIFO head whenever dout_valid=1.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   mac_clr      synchronous clear of accumulator and term counter (wins over mac_en)
//   mac_en       a_in/b_in hold a term this cycle
//   a_in, b_in   unsigned operands
//   dout         registered FIFO head
//   dout_valid   FIFO non-empty
//   dout_ready   consumer takes the head this cycle
//   result_done  one-cycle pulse per completed result (stored or dropped)
//   fifo_count   entries held, 0..DEPTH
//   fifo_full    fifo_count == DEPTH
//   overflow     sticky: a completed result was dropped; cleared only by reset
//   dbg_cnt      term counter, which is the accumulator's state
module mac_result_buffer #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 20,
  parameter int N_TERMS = 3,
  parameter int DEPTH   = 4,
  localparam int CNT_W  = (N_TERMS > 1) ? $clog2(N_TERMS) : 1,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int FC_W   = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mac_clr,
  input  logic              mac_en,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [ACC_W-1:0]  dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              result_done,
  output logic [FC_W-1:0]   fifo_count,
  output logic              fifo_full,
  output logic              overflow,
  output logic [CNT_W-1:0]  dbg_cnt
);

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(N_TERMS - 1);
  localparam logic [FC_W-1:0]  FC_MAX = FC_W'(DEPTH);

  // ---------------------------------------------------------------------------
  // Accumulator: the term counter is the state (0 = idle / first term).
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [ACC_W-1:0]    acc, acc_nxt;
  logic [2*DATA_W-1:0] prod_full;
  logic [ACC_W-1:0]    product;
  logic [ACC_W-1:0]    result;
  logic                push_req;

  assign prod_full = a_in * b_in;
  assign product   = ACC_W'(prod_full);
  assign dbg_cnt   = cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      acc <= '0;
    end else begin
      cnt <= cnt_nxt;
      acc <= acc_nxt;
    end
  end

  always_comb begin
    cnt_nxt  = cnt;
    acc_nxt  = acc;
    push_req = 1'b0;
    // acc is always zero at cnt=0, so this is also correct for N_TERMS=1.
    result   = acc + product;
    if (mac_clr) begin
      cnt_nxt = '0;
      acc_nxt = '0;
    end else if (mac_en) begin
      if (cnt == LAST) begin
        cnt_nxt  = '0;
        acc_nxt  = '0;
        push_req = 1'b1;
      end else if (cnt == '0) begin
        cnt_nxt = cnt + 1'b1;
        acc_nxt = product;
      end else begin
        cnt_nxt = cnt + 1'b1;
        acc_nxt = acc + product;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO with a registered head.
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic             pop, push_ok, drop;

  assign dout_valid = (fifo_count != '0);
  assign fifo_full  = (fifo_count == FC_MAX);
  assign pop        = dout_valid & dout_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok    = push_req & (~fifo_full | pop);
  assign drop       = push_req & fifo_full & ~pop;
  assign rd_nxt     = rd_ptr + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_count  <= '0;
      dout        <= '0;
      overflow    <= 1'b0;
      result_done <= 1'b0;
    end else begin
      result_done <= push_req;
      overflow    <= overflow | drop;

      if (push_ok) begin
        mem[wr_ptr] <= result;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_nxt;

      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      // Head update. When the last entry leaves while a new one arrives, the
      // new result bypasses the array. With DEPTH >= 2, mem[rd_nxt] is never
      // the slot being written this cycle whenever it is read here.
      if (pop) begin
        if (fifo_count == FC_W'(1)) begin
          if (push_ok) dout <= result;
        end else begin
          dout <= mem[rd_nxt];
        end
      end else if (push_ok && fifo_count == '0) begin
        dout <= result;
      end
    end
  end

endmodule

// File: tb/tb_mac_result_buffer.sv
module tb_mac_result_buffer;

  localparam int DATA_W  = 8;
  localparam int ACC_W   = 20;
  localparam int N_TERMS = 3;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = $clog2(N_TERMS);
  localparam int FC_W    = $clog2(DEPTH) + 1;
  localparam longint ACC_MASK = (64'd1 << ACC_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              mac_clr = 1'b0;
  logic              mac_en  = 1'b0;
  logic [DATA_W-1:0] a_in    = '0;
  logic [DATA_W-1:0] b_in    = '0;
  logic              dout_ready = 1'b0;
  logic [ACC_W-1:0]  dout;
  logic              dout_valid;
  logic              result_done;
  logic [FC_W-1:0]   fifo_count;
  logic              fifo_full;
  logic              overflow;
  logic [CNT_W-1:0]  dbg_cnt;

  mac_result_buffer #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .N_TERMS(N_TERMS), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .mac_clr(mac_clr), .mac_en(mac_en),
    .a_in(a_in), .b_in(b_in), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .result_done(result_done),
    .fifo_count(fifo_count), .fifo_full(fifo_full), .overflow(overflow),
    .dbg_cnt(dbg_cnt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  // exp_q models the FIFO contents; the partial dot product is a plain sum.
  logic [ACC_W-1:0] exp_q[$];
  logic [ACC_W-1:0] pop_log[$];
  longint m_sum  = 0;
  int     m_n    = 0;
  bit     m_ovf  = 0;
  bit     m_done = 0;
  int     done_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_dout", dout, 0);
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_result_done", result_done, 0);
      chk("rst_fifo_count", fifo_count, 0);
      chk("rst_fifo_full", fifo_full, 0);
      chk("rst_overflow", overflow, 0);
      exp_q.delete();
      m_sum = 0; m_n = 0; m_ovf = 0; m_done = 0;
    end else begin
      chk("fifo_count", fifo_count, exp_q.size());
      chk("dout_valid", dout_valid, exp_q.size() != 0);
      chk("fifo_full", fifo_full, exp_q.size() == DEPTH);
      chk("overflow", overflow, m_ovf);
      chk("result_done", result_done, m_done);
      chk("term_count", dbg_cnt, m_n);
      if (result_done) done_cnt++;
      m_done = 0;
      // Predict the coming edge: pop first, then the term.
      if (dout_ready && exp_q.size() != 0) begin
        chk("dout", dout, exp_q[0]);
        pop_log.push_back(dout);
        void'(exp_q.pop_front());
      end
      if (mac_clr) begin
        m_sum = 0; m_n = 0;
      end else if (mac_en) begin
        m_sum += longint'(a_in) * longint'(b_in);
        m_n++;
        if (m_n == N_TERMS) begin
          m_done = 1;
          if (exp_q.size() == DEPTH) m_ovf = 1;
          else exp_q.push_back(ACC_W'(m_sum & ACC_MASK));
          m_sum = 0; m_n = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic en, input logic clr, input int a, input int b,
                     input logic rdy);
    @(posedge clk); #1;
    mac_en = en; mac_clr = clr; a_in = DATA_W'(a); b_in = DATA_W'(b);
    dout_ready = rdy;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, rdy);
  endtask

  task automatic element(input int a0, b0, a1, b1, a2, b2, input logic rdy);
    cyc(1, 0, a0, b0, rdy);
    cyc(1, 0, a1, b1, rdy);
    cyc(1, 0, a2, b2, rdy);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    cyc(0, 0, 0, 0, 1);
    while (dout_valid && n < 40) begin
      cyc(0, 0, 0, 0, 1);
      n++;
    end
    chk({name, "_drain_timeout"}, n >= 40, 0);
    idle(2, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; mac_en = 0; mac_clr = 0; dout_ready = 0;
    idle(2, 0);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic check_log(input string name, input int n,
                           input longint e0, e1, e2, e3, e4);
    longint e[5];
    e = '{e0, e1, e2, e3, e4};
    chk({name, "_pop_count"}, pop_log.size(), n);
    for (int i = 0; i < n; i++)
      if (i < pop_log.size()) chk({name, "_pop_value"}, pop_log[i], e[i]);
  endtask

  // ---------------- stimulus ----------------
  int d0;

  initial begin
    #1 reset = 1'b0;
    // Reset held with random inputs.
    for (int i = 0; i < 3; i++)
      cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 255),
          $urandom_range(0, 255), $urandom_range(0, 1));
    @(posedge clk); #1;
    reset = 1'b1; mac_en = 0; mac_clr = 0; dout_ready = 0;
    idle(5, 0);

    // Single result.
    pop_log.delete();
    element(2, 3, 4, 5, 6, 7, 1);
    drain("single");
    check_log("single", 1, 68, 0, 0, 0, 0);

    // Max operands.
    pop_log.delete();
    element(255, 255, 255, 255, 255, 255, 1);
    drain("max");
    check_log("max", 1, 195075, 0, 0, 0, 0);

    // Backpressure and overflow.
    pop_log.delete();
    d0 = done_cnt;
    for (int i = 1; i <= 5; i++) element(i, i, i, i, i, i, 0);
    idle(2, 0);
    chk("bp_fifo_full", fifo_full, 1);
    chk("bp_overflow", overflow, 1);
    chk("bp_done_pulses", done_cnt - d0, 5);
    drain("bp");
    check_log("bp", 4, 3, 12, 27, 48, 0);
    chk("bp_overflow_sticky", overflow, 1);

    // Clear mid-element, clear wins over a simultaneous term.
    pop_log.delete();
    d0 = done_cnt;
    cyc(1, 0, 9, 9, 1);
    cyc(1, 0, 9, 9, 1);
    cyc(1, 1, 10, 10, 1);
    idle(2, 1);
    chk("clr_no_done", done_cnt - d0, 0);
    chk("clr_no_push", fifo_count, 0);
    element(1, 1, 1, 2, 1, 3, 1);
    drain("clr");
    check_log("clr", 1, 6, 0, 0, 0, 0);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    pop_log.delete();
    for (int i = 1; i <= 4; i++) element(i, i, i, i, i, i, 0);
    cyc(1, 0, 5, 5, 0);
    cyc(1, 0, 5, 5, 0);
    cyc(1, 0, 5, 5, 1);
    cyc(0, 0, 0, 0, 0);
    chk("pp_fifo_count", fifo_count, 4);
    chk("pp_overflow", overflow, 0);
    drain("pp");
    check_log("pp", 5, 3, 12, 27, 48, 75);

    // Asynchronous reset between edges with two entries held.
    element(7, 1, 7, 1, 7, 1, 0);
    element(8, 1, 8, 1, 8, 1, 0);
    cyc(1, 0, 3, 3, 0);
    @(posedge clk); #3;
    chk("ar_count_before", fifo_count, 2);
    reset = 1'b0;
    #1;
    chk("ar_dout", dout, 0);
    chk("ar_dout_valid", dout_valid, 0);
    chk("ar_fifo_count", fifo_count, 0);
    chk("ar_fifo_full", fifo_full, 0);
    chk("ar_overflow", overflow, 0);
    chk("ar_result_done", result_done, 0);
    chk("ar_term_count", dbg_cnt, 0);
    @(posedge clk); #1;
    mac_en = 0; mac_clr = 0;
    reset = 1'b1;
    idle(2, 0);

    // Randomised traffic checked by the scoreboard.
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
          $urandom_range(0, 255), $urandom_range(0, 255),
          $urandom_range(0, 2) != 0);
    drain("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
